// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared types and helpers for the digit-serial adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder : one-bit combinational full adder cell
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle a+b+cin, DIGIT bits per clock via a ripple chain
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int c_NUM_DIGITS = WIDTH / DIGIT;
  localparam int c_CNT_W      = cnt_width(c_NUM_DIGITS);
  localparam logic [c_CNT_W-1:0] c_LAST_DIGIT = c_CNT_W'(c_NUM_DIGITS - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_range
    $error("serial_adder: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
  end

  sa_state_t          state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT:0]     chain_c;
  logic [DIGIT-1:0]   digit_s;

  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (chain_c[i]),
      .sum  (digit_s[i]),
      .cout (chain_c[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // Result digits enter at the top so the LSB digit lands at bit 0 last.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(digit_s) << (WIDTH - DIGIT));
        carry_d = chain_c[DIGIT];
        cnt_d   = cnt_q + c_CNT_W'(1);
        if (cnt_q == c_LAST_DIGIT) begin
          state_d = DONE;
          cout_d  = chain_c[DIGIT];
          ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : four adder configurations checked against an arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int c_NINST = 4;

  logic       clk = 1'b0;
  logic [3:0] rst_s;
  logic [3:0] start_s;
  logic [3:0] cin_s;
  logic [7:0] a_s   [c_NINST];
  logic [7:0] b_s   [c_NINST];
  logic [3:0] busy_s;
  logic [3:0] done_s;
  logic [3:0] cout_s;
  logic [3:0] ovf_s;
  logic [7:0] sum_s [c_NINST];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int wof(input int g);
    return (g < 2) ? 8 : 4;
  endfunction

  function automatic int dof(input int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < c_NINST; g++) begin : g_dut
    localparam int W = (g < 2) ? 8 : 4;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 1 : 2;
    logic [W-1:0] s;
    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk      (clk),
      .reset    (rst_s[g]),
      .start    (start_s[g]),
      .a        (a_s[g][W-1:0]),
      .b        (b_s[g][W-1:0]),
      .cin      (cin_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .sum      (s),
      .cout     (cout_s[g]),
      .overflow (ovf_s[g])
    );
    assign sum_s[g] = 8'(s);
  end

  task automatic check(input string name, input int g, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, g, got, exp, $time);
    end
  endtask

  // Model: operation accepted when not busy, result appears N cycles later.
  bit         m_busy [c_NINST];
  bit         m_done [c_NINST];
  int         m_left [c_NINST];
  int         m_sum  [c_NINST];
  int         m_cout [c_NINST];
  int         m_ovf  [c_NINST];
  int         p_sum  [c_NINST];
  int         p_cout [c_NINST];
  int         p_ovf  [c_NINST];

  always @(posedge clk) begin : model
    int w, ua, ub, uc, tot, sa, sb, st;
    for (int g = 0; g < c_NINST; g++) begin
      w = wof(g);
      if (rst_s[g]) begin
        m_busy[g] = 0; m_done[g] = 0; m_left[g] = 0;
        m_sum[g] = 0; m_cout[g] = 0; m_ovf[g] = 0;
      end else if (!m_busy[g] && start_s[g]) begin
        ua  = int'(a_s[g]) % (1 << w);
        ub  = int'(b_s[g]) % (1 << w);
        uc  = int'(cin_s[g]);
        tot = ua + ub + uc;
        p_sum[g]  = tot % (1 << w);
        p_cout[g] = tot >> w;
        sa  = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb  = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        st  = sa + sb + uc;
        p_ovf[g]  = (st > (1 << (w - 1)) - 1 || st < -(1 << (w - 1))) ? 1 : 0;
        m_busy[g] = 1; m_done[g] = 0; m_left[g] = (w / dof(g));
      end else if (m_busy[g]) begin
        m_left[g] = m_left[g] - 1;
        if (m_left[g] == 0) begin
          m_busy[g] = 0; m_done[g] = 1;
          m_sum[g] = p_sum[g]; m_cout[g] = p_cout[g]; m_ovf[g] = p_ovf[g];
        end
      end else begin
        m_done[g] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < c_NINST; g++) begin
        check("busy", g, int'(busy_s[g]), int'(m_busy[g]));
        check("done", g, int'(done_s[g]), int'(m_done[g]));
        if (!m_busy[g]) begin
          check("sum", g, int'(sum_s[g]), m_sum[g]);
          check("cout", g, int'(cout_s[g]), m_cout[g]);
          check("overflow", g, int'(ovf_s[g]), m_ovf[g]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic op(input int g, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                    input bit scramble, input bit hold, output int nbusy, output bit ok);
    int t;
    a_s[g] = av; b_s[g] = bv; cin_s[g] = cv; start_s[g] = 1'b1;
    t = 0;
    while (busy_s[g] && t < 64) begin @(negedge clk); t++; end
    @(negedge clk);
    nbusy = 0;
    while (busy_s[g] && nbusy < 64) begin
      if (scramble) begin
        a_s[g] = 8'($urandom); b_s[g] = 8'($urandom); cin_s[g] = 1'($urandom);
      end else if (!hold) begin
        start_s[g] = 1'b0;
      end
      nbusy++;
      @(negedge clk);
    end
    if (!hold) start_s[g] = 1'b0;
    ok = done_s[g];
    if (t >= 64 || nbusy >= 64) check("timeout", g, 1, 0);
  endtask

  task automatic run_exh(input int g);
    int  nb;
    bit  ok;
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int cv = 0; cv < 2; cv++) begin
          op(g, 8'(av), 8'(bv), 1'(cv), 1'b0, 1'b1, nb, ok);
          check("exh_latency", g, nb, 4 / dof(g));
          check("exh_result", g, {27'd0, cout_s[g], sum_s[g][3:0]}, av + bv + cv);
        end
    start_s[g] = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int nb;
    bit ok;
    rst_s = '1; start_s = '0; cin_s = '0;
    for (int g = 0; g < c_NINST; g++) begin a_s[g] = '0; b_s[g] = '0; end
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 0, int'(busy_s[0]), 0);
    check("reset_sum", 0, int'(sum_s[0]), 0);
    rst_s = '0;
    @(negedge clk);

    // Carry wrap
    op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, nb, ok);
    check("wrap_busy_cycles", 0, nb, 8);
    check("wrap_done", 0, int'(ok), 1);
    check("wrap_sum", 0, int'(sum_s[0]), 8'h00);
    check("wrap_cout", 0, int'(cout_s[0]), 1);
    check("wrap_ovf", 0, int'(ovf_s[0]), 0);
    @(negedge clk);

    // Signed overflow, then full-carry case
    op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, nb, ok);
    check("ovf_sum", 0, int'(sum_s[0]), 8'h80);
    check("ovf_cout", 0, int'(cout_s[0]), 0);
    check("ovf_flag", 0, int'(ovf_s[0]), 1);
    op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, nb, ok);
    check("a5_sum", 0, int'(sum_s[0]), 8'h00);
    check("a5_cout", 0, int'(cout_s[0]), 1);
    check("a5_ovf", 0, int'(ovf_s[0]), 0);

    // Wide digit
    op(1, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, nb, ok);
    check("wide_busy_cycles", 1, nb, 2);
    check("wide_done", 1, int'(ok), 1);
    check("wide_sum", 1, int'(sum_s[1]), 8'h4B);
    check("wide_cout", 1, int'(cout_s[1]), 0);

    // Handshake robustness: start held and operands churned throughout RUN
    op(0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, nb, ok);
    check("hold_sum", 0, int'(sum_s[0]), 8'h47);
    check("hold_busy_cycles", 0, nb, 8);
    repeat (3) begin
      @(negedge clk);
      check("hold_single_done", 0, int'(done_s[0]), 0);
    end

    // Reset while digit 3 is being added
    a_s[0] = 8'hC3; b_s[0] = 8'h3D; cin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    check("rst_busy", 0, int'(busy_s[0]), 0);
    check("rst_done", 0, int'(done_s[0]), 0);
    check("rst_sum", 0, int'(sum_s[0]), 0);
    check("rst_cout", 0, int'(cout_s[0]), 0);
    check("rst_ovf", 0, int'(ovf_s[0]), 0);
    repeat (10) begin
      @(negedge clk);
      check("rst_no_done", 0, int'(done_s[0]), 0);
    end
    op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, nb, ok);
    check("post_rst_sum", 0, int'(sum_s[0]), 8'h46);
    check("post_rst_done", 0, int'(ok), 1);

    // Exhaustive, back-to-back
    fork
      run_exh(2);
      run_exh(3);
    join

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
